ieee_adder_arbiter: RTL and testbench
=====================================

Name: ieee_adder_arbiter

Overview:
- Round-robin arbiter sharing one pipelined ieee_adder instance among NUM_REQ requesters.
- Accepts at most one operation per cycle over a valid/ready handshake and drives the adder's add_sub_bit, inputA and inputB from registers.
- Tracks each issued operation's requester ID through a tag pipeline matched to ADDER_LATENCY.
- Returns each outputC to the originating requester with a one-cycle result-valid pulse.
- Sits between the FPU client logic and the ieee_adder datapath; the adder itself is instantiated outside this block.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
ADDER_LATENCY, 4, rising clock_in edges from adder inputs changing to outputC reflecting them (>=1)
ID_W, 2, width of requester index; must equal clog2(NUM_REQ)

Ports:
clock_in  in  1  single clock, rising edge
reset_n_in  in  1  asynchronous active-low reset
req_valid_in  in  NUM_REQ  per-requester operation request
req_ready_out  out  NUM_REQ  one-hot grant; handshake completes where valid & ready
req_add_sub_in  in  NUM_REQ  per-requester op: 0 add, 1 subtract
req_a_in  in  32*NUM_REQ  flattened operand A, requester i at [32i+31:32i]
req_b_in  in  32*NUM_REQ  flattened operand B
res_valid_out  out  NUM_REQ  one-hot, one-cycle result strobe
res_data_out  out  32  result word, shared by all requesters
res_id_out  out  ID_W  index of requester owning res_data_out
adder_add_sub_out  out  1  to ieee_adder add_sub_bit
adder_a_out  out  32  to ieee_adder inputA
adder_b_out  out  32  to ieee_adder inputB
adder_c_in  in  32  from ieee_adder outputC
in_flight_out  out  4  operations issued but not yet returned (0..ADDER_LATENCY+1)

Behaviour:
- Reset (async assert, sync release):
  - rr_ptr=0; tag pipeline all invalid.
  - res_valid_out=0, res_data_out=0, res_id_out=0.
  - adder_add_sub_out=0, adder_a_out=0, adder_b_out=0, in_flight_out=0.
- Arbitration (combinational):
  - Grant the first requester with req_valid_in set, searching rr_ptr, rr_ptr+1, ... modulo NUM_REQ.
  - req_ready_out is one-hot at the granted index, 0 if no request.
  - No backpressure: a pending request is always granted when present.
- Grant at edge k:
  - Register the granted requester's add_sub, A and B into adder_*_out.
  - Push {valid=1, id} into tag stage 0.
  - rr_ptr <= granted index + 1, wrapping NUM_REQ-1 to 0.
- No grant:
  - adder_*_out hold their last values.
  - Push {valid=0} into the tag pipeline.
  - rr_ptr unchanged.
- Tag pipeline: ADDER_LATENCY stages, shifting every cycle; it never stalls.
- Return:
  - When the last tag stage is valid, the next edge registers res_data_out <= adder_c_in and res_id_out <= id, and pulses res_valid_out[id] for 1 cycle.
  - Otherwise res_valid_out = 0 and res_data_out / res_id_out hold.
- Latency: handshake at edge k gives res_valid_out at edge k+ADDER_LATENCY+1. Throughput is 1 op/cycle.
- Ordering: results return in grant order. Back-to-back grants give back-to-back res_valid pulses.
- in_flight_out:
  - +1 on a grant; -1 when res_valid_out asserts.
  - Simultaneous grant and return leaves it unchanged.
- Requesters must accept results unconditionally; there is no result backpressure.
- A requester may drop req_valid_in without a grant; nothing is issued for it.
- Operand/add_sub changes while the request is not granted are allowed; the values sampled at the grant edge are used.
- Reset mid-operation: all in-flight tags are discarded, no res_valid pulses follow, and rr_ptr returns to 0.

Test Plan:
- Single op: after reset, req0 issues add 0x3FC00000 + 0x3F000000 (1.5+0.5) -> res_valid_out=0001 exactly ADDER_LATENCY+1 cycles after the handshake; res_data=0x40000000; res_id=0; in_flight 0->1->0.
- Subtract: req2 issues sub 0x40400000 - 0x3F800000 (3.0-1.0) -> res_valid_out=0100, res_data=0x40000000.
- Full contention: all 4 requesters hold req_valid for 8 cycles; req_i computes (i+1.0)+4.0 -> grants 0,1,2,3,0,1,2,3 on consecutive cycles.
  - Results are 0x40A00000, 0x40C00000, 0x40E00000, 0x41000000, repeated in grant order with no gaps.
  - in_flight peaks at ADDER_LATENCY+1.
- Round-robin fairness: req1 and req3 continuously request after the last grant went to 2 -> grant order 3,1,3,1; req0 raised later is granted within NUM_REQ cycles.
- Idle gaps: req0 issues 8.0+7.0, 2 idle cycles, then req0 issues 0.5+7.5 -> res_data 0x41700000 then 0x41000000, with the same 2-cycle gap between pulses; adder_*_out held during the idle cycles.
- Reset mid-flight: issue 3 ops, then assert reset_n_in 2 cycles later for 1 cycle -> all outputs zero immediately, no res_valid afterwards, and the next op after release is granted to the lowest requesting index.

Source files
------------

// File: rtl/ieee_adder_arbiter_if.sv
// ieee_adder_arbiter_if
//   Bundles the requester-side handshake, result return and adder-side
//   signals of ieee_adder_arbiter.
//   slave  : arbiter view (drives grants, results and adder operands)
//   master : client/adder view (drives requests and adder_c_in)
//   req_*        per-requester valid / op / operands, one-hot ready
//   res_*        one-hot result strobe, shared result word, owner index
//   adder_*      register-driven adder operands and returned outputC
//   in_flight_out count of issued but not yet returned operations
interface ieee_adder_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
);
    logic [NUM_REQ-1:0]    req_valid_in;
    logic [NUM_REQ-1:0]    req_ready_out;
    logic [NUM_REQ-1:0]    req_add_sub_in;
    logic [32*NUM_REQ-1:0] req_a_in;
    logic [32*NUM_REQ-1:0] req_b_in;
    logic [NUM_REQ-1:0]    res_valid_out;
    logic [31:0]           res_data_out;
    logic [ID_W-1:0]       res_id_out;
    logic                  adder_add_sub_out;
    logic [31:0]           adder_a_out;
    logic [31:0]           adder_b_out;
    logic [31:0]           adder_c_in;
    logic [3:0]            in_flight_out;

    modport slave (
        input  req_valid_in, req_add_sub_in, req_a_in, req_b_in, adder_c_in,
        output req_ready_out, res_valid_out, res_data_out, res_id_out,
               adder_add_sub_out, adder_a_out, adder_b_out, in_flight_out
    );

    modport master (
        output req_valid_in, req_add_sub_in, req_a_in, req_b_in, adder_c_in,
        input  req_ready_out, res_valid_out, res_data_out, res_id_out,
               adder_add_sub_out, adder_a_out, adder_b_out, in_flight_out
    );
endinterface

// File: rtl/ieee_adder_arbiter.sv
// ieee_adder_arbiter
//   Round-robin arbiter sharing one external pipelined ieee_adder among
//   NUM_REQ requesters. One operation is granted per cycle; the granted
//   operands are registered onto the adder inputs and the requester index
//   travels down a tag pipeline so that the adder's outputC is returned
//   to its owner with a one-cycle res_valid_out pulse.
//   Ports:
//     clock_in    rising-edge clock
//     reset_n_in  asynchronous active-low reset
//     bus         ieee_adder_arbiter_if.slave (requests, results, adder)
module ieee_adder_arbiter #(
    parameter int NUM_REQ       = 4,
    parameter int ADDER_LATENCY = 4,
    parameter int ID_W          = 2
) (
    input  logic                 clock_in,
    input  logic                 reset_n_in,
    ieee_adder_arbiter_if.slave  bus
);
    localparam int L = ADDER_LATENCY;

    logic [ID_W-1:0] rr_ptr;
    logic            grant_vld;
    logic [ID_W-1:0] grant_idx;
    logic [ID_W:0]   cand_sum;
    logic [ID_W-1:0] cand;

    // The adder inputs change at the grant edge k and outputC is valid after
    // edge k+L, so the tag must be visible at the end of the chain during
    // the cycle following edge k+L. Stage 0 is loaded at edge k, hence L+1
    // entries, and the result register loads at edge k+L+1.
    logic [L:0]           vld_pipe;
    logic [L:0][ID_W-1:0] id_pipe;

    // Round-robin search starting at rr_ptr, wrapping modulo NUM_REQ.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        cand_sum  = '0;
        cand      = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand_sum = {1'b0, rr_ptr} + (ID_W+1)'(i);
            if (cand_sum >= (ID_W+1)'(NUM_REQ))
                cand_sum = cand_sum - (ID_W+1)'(NUM_REQ);
            cand = cand_sum[ID_W-1:0];
            if (!grant_vld && bus.req_valid_in[cand]) begin
                grant_vld = 1'b1;
                grant_idx = cand;
            end
        end
    end

    assign bus.req_ready_out = grant_vld ? (NUM_REQ'(1) << grant_idx) : '0;

    // Issue side: operand registers, round-robin pointer.
    always_ff @(posedge clock_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            rr_ptr                <= '0;
            bus.adder_add_sub_out <= 1'b0;
            bus.adder_a_out       <= '0;
            bus.adder_b_out       <= '0;
        end else if (grant_vld) begin
            bus.adder_add_sub_out <= bus.req_add_sub_in[grant_idx];
            bus.adder_a_out       <= bus.req_a_in[32*grant_idx +: 32];
            bus.adder_b_out       <= bus.req_b_in[32*grant_idx +: 32];
            rr_ptr <= (grant_idx == ID_W'(NUM_REQ-1)) ? '0 : grant_idx + 1'b1;
        end
    end

    // Tag pipeline never stalls; a bubble is pushed on cycles without grant.
    always_ff @(posedge clock_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            vld_pipe <= '0;
            id_pipe  <= '0;
        end else begin
            vld_pipe <= {vld_pipe[L-1:0], grant_vld};
            id_pipe  <= {id_pipe[L-1:0], grant_idx};
        end
    end

    // Return side.
    always_ff @(posedge clock_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            bus.res_valid_out <= '0;
            bus.res_data_out  <= '0;
            bus.res_id_out    <= '0;
        end else if (vld_pipe[L]) begin
            bus.res_valid_out <= NUM_REQ'(1) << id_pipe[L];
            bus.res_data_out  <= bus.adder_c_in;
            bus.res_id_out    <= id_pipe[L];
        end else begin
            bus.res_valid_out <= '0;
        end
    end

    // Decrement at the same edge the result strobe is raised, so the count
    // peaks at L+1 under back-to-back traffic.
    always_ff @(posedge clock_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            bus.in_flight_out <= '0;
        end else begin
            case ({grant_vld, vld_pipe[L]})
                2'b10:   bus.in_flight_out <= bus.in_flight_out + 4'd1;
                2'b01:   bus.in_flight_out <= bus.in_flight_out - 4'd1;
                default: bus.in_flight_out <= bus.in_flight_out;
            endcase
        end
    end
endmodule

// File: tb/tb_ieee_adder_arbiter.sv
module tb_ieee_adder_arbiter;
    localparam int NR  = 4;
    localparam int LAT = 4;
    localparam int IW  = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ieee_adder_arbiter_if #(.NUM_REQ(NR), .ID_W(IW)) bus();

    ieee_adder_arbiter #(.NUM_REQ(NR), .ADDER_LATENCY(LAT), .ID_W(IW)) dut (
        .clock_in   (clk),
        .reset_n_in (rst_n),
        .bus        (bus)
    );

    int vectors = 0;
    int errs    = 0;

    // Behavioural single-precision adder (normal numbers only) used as the
    // external ieee_adder with LAT cycles of latency.
    function automatic real s2r(input logic [31:0] x);
        logic [10:0] e;
        if (x[30:0] == 31'd0) return 0.0;
        e = 11'(x[30:23]) + 11'd896;
        return $bitstoreal({x[31], e, x[22:0], 29'd0});
    endfunction

    function automatic logic [31:0] r2s(input real r);
        logic [63:0] d;
        logic [10:0] e;
        d = $realtobits(r);
        if (d[62:0] == 63'd0) return {d[63], 31'd0};
        e = d[62:52] - 11'd896;
        return {d[63], e[7:0], d[51:29]};
    endfunction

    function automatic logic [31:0] fadd(input logic s, input logic [31:0] a, input logic [31:0] b);
        return r2s(s ? (s2r(a) - s2r(b)) : (s2r(a) + s2r(b)));
    endfunction

    logic [31:0] mp [LAT];
    always @(posedge clk) begin
        mp[0] <= fadd(bus.adder_add_sub_out, bus.adder_a_out, bus.adder_b_out);
        for (int i = 1; i < LAT; i++) mp[i] <= mp[i-1];
    end
    assign bus.adder_c_in = mp[LAT-1];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input int i, input logic s, input logic [31:0] a, input logic [31:0] b);
        bus.req_add_sub_in[i]   = s;
        bus.req_a_in[32*i +: 32] = a;
        bus.req_b_in[32*i +: 32] = b;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_rv"},  32'(bus.res_valid_out), 32'd0);
        chk({tag, "_rd"},  bus.res_data_out, 32'd0);
        chk({tag, "_rid"}, 32'(bus.res_id_out), 32'd0);
        chk({tag, "_as"},  32'(bus.adder_add_sub_out), 32'd0);
        chk({tag, "_a"},   bus.adder_a_out, 32'd0);
        chk({tag, "_b"},   bus.adder_b_out, 32'd0);
        chk({tag, "_inf"}, 32'(bus.in_flight_out), 32'd0);
    endtask

    logic [31:0] cres [4] = '{32'h40A00000, 32'h40C00000, 32'h40E00000, 32'h41000000};
    logic [31:0] ca   [4] = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000};
    int          cinf [13] = '{1, 2, 3, 4, 5, 5, 5, 5, 4, 3, 2, 1, 0};
    logic [3:0]  fseq [4] = '{4'b1000, 4'b0010, 4'b1000, 4'b0010};

    initial begin
        bus.req_valid_in   = '0;
        bus.req_add_sub_in = '0;
        bus.req_a_in       = '0;
        bus.req_b_in       = '0;
        tick();
        tick();
        chk_all_zero("reset");
        rst_n = 1'b1;
        tick();

        // Single add on requester 0: 1.5 + 0.5
        set_op(0, 1'b0, 32'h3FC00000, 32'h3F000000);
        bus.req_valid_in = 4'b0001;
        #1 chk("single_ready", 32'(bus.req_ready_out), 32'h1);
        tick();
        bus.req_valid_in = '0;
        chk("single_inf1", 32'(bus.in_flight_out), 32'd1);
        chk("single_a", bus.adder_a_out, 32'h3FC00000);
        chk("single_b", bus.adder_b_out, 32'h3F000000);
        chk("single_as", 32'(bus.adder_add_sub_out), 32'd0);
        repeat (LAT) begin
            tick();
            chk("single_wait", 32'(bus.res_valid_out), 32'd0);
            chk("single_wait_inf", 32'(bus.in_flight_out), 32'd1);
        end
        tick();
        chk("single_rv", 32'(bus.res_valid_out), 32'h1);
        chk("single_rd", bus.res_data_out, 32'h40000000);
        chk("single_rid", 32'(bus.res_id_out), 32'd0);
        chk("single_inf0", 32'(bus.in_flight_out), 32'd0);
        tick();
        chk("single_pulse", 32'(bus.res_valid_out), 32'd0);
        chk("single_hold", bus.res_data_out, 32'h40000000);

        // Subtract on requester 2: 3.0 - 1.0
        set_op(2, 1'b1, 32'h40400000, 32'h3F800000);
        bus.req_valid_in = 4'b0100;
        #1 chk("sub_ready", 32'(bus.req_ready_out), 32'h4);
        tick();
        bus.req_valid_in = '0;
        chk("sub_as", 32'(bus.adder_add_sub_out), 32'd1);
        repeat (LAT) tick();
        tick();
        chk("sub_rv", 32'(bus.res_valid_out), 32'h4);
        chk("sub_rd", bus.res_data_out, 32'h40000000);
        chk("sub_rid", 32'(bus.res_id_out), 32'd2);

        // Fairness: last grant was 2, req1 and req3 contend
        set_op(1, 1'b0, 32'h3F800000, 32'h3F800000);
        set_op(3, 1'b0, 32'h3F800000, 32'h3F800000);
        bus.req_valid_in = 4'b1010;
        for (int c = 0; c < 4; c++) begin
            #1 chk("rr_seq", 32'(bus.req_ready_out), 32'(fseq[c]));
            tick();
        end
        bus.req_valid_in = 4'b1011;
        #1 chk("rr_late0_a", 32'(bus.req_ready_out), 32'h8);
        tick();
        #1 chk("rr_late0_b", 32'(bus.req_ready_out), 32'h1);
        tick();
        bus.req_valid_in = '0;

        rst_n = 1'b0;
        #1 chk("rst2_inf", 32'(bus.in_flight_out), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();

        // Full contention: req_i computes (i+1.0)+4.0
        for (int i = 0; i < NR; i++) set_op(i, 1'b0, ca[i], 32'h40800000);
        for (int c = 0; c < 13; c++) begin
            bus.req_valid_in = (c < 8) ? 4'hF : 4'h0;
            #1 chk("cont_ready", 32'(bus.req_ready_out), (c < 8) ? (32'h1 << (c % 4)) : 32'h0);
            tick();
            if (c >= 5) begin
                chk("cont_rv", 32'(bus.res_valid_out), 32'h1 << ((c - 5) % 4));
                chk("cont_rd", bus.res_data_out, cres[(c - 5) % 4]);
                chk("cont_rid", 32'(bus.res_id_out), 32'((c - 5) % 4));
            end else begin
                chk("cont_rv0", 32'(bus.res_valid_out), 32'd0);
            end
            chk("cont_inf", 32'(bus.in_flight_out), 32'(cinf[c]));
        end

        // Idle gaps: 8.0+7.0, two idle cycles, 0.5+7.5
        for (int c = 0; c < 10; c++) begin
            if (c == 0) set_op(0, 1'b0, 32'h41000000, 32'h40E00000);
            if (c == 3) set_op(0, 1'b0, 32'h3F000000, 32'h40F00000);
            bus.req_valid_in = (c == 0 || c == 3) ? 4'b0001 : 4'b0000;
            tick();
            if (c == 1 || c == 2) begin
                chk("idle_hold_a", bus.adder_a_out, 32'h41000000);
                chk("idle_hold_b", bus.adder_b_out, 32'h40E00000);
            end
            if (c == 5) begin
                chk("idle_rv1", 32'(bus.res_valid_out), 32'h1);
                chk("idle_rd1", bus.res_data_out, 32'h41700000);
            end else if (c == 8) begin
                chk("idle_rv2", 32'(bus.res_valid_out), 32'h1);
                chk("idle_rd2", bus.res_data_out, 32'h41000000);
            end else begin
                chk("idle_rv0", 32'(bus.res_valid_out), 32'd0);
            end
        end

        // Reset mid-flight: three grants (1,2,3), then reset two cycles later
        set_op(1, 1'b0, 32'h40000000, 32'h3F800000);
        set_op(2, 1'b0, 32'h40400000, 32'h3F800000);
        set_op(3, 1'b0, 32'h40800000, 32'h3F800000);
        bus.req_valid_in = 4'b1110;
        repeat (3) tick();
        bus.req_valid_in = '0;
        tick();
        tick();
        chk("mid_inf3", 32'(bus.in_flight_out), 32'd3);
        rst_n = 1'b0;
        #1 chk_all_zero("mid_rst");
        tick();
        rst_n = 1'b1;
        repeat (8) begin
            tick();
            chk("mid_norv", 32'(bus.res_valid_out), 32'd0);
        end
        bus.req_valid_in = 4'b1010;
        #1 chk("mid_ready", 32'(bus.req_ready_out), 32'h2);
        tick();
        bus.req_valid_in = '0;
        chk("mid_a", bus.adder_a_out, 32'h40000000);
        repeat (LAT) tick();
        tick();
        chk("mid_rv", 32'(bus.res_valid_out), 32'h2);
        chk("mid_rd", bus.res_data_out, 32'h40400000);
        chk("mid_rid", 32'(bus.res_id_out), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end
endmodule
